// File: rtl/wb_pipe_reg.sv
// wb_pipe_reg: elastic MEM/WB write-back pipeline of DEPTH register stages.
// Carries mo, alu, rn, wreg and m2reg through a valid/ready pipe.
// Supports back-pressure, synchronous flush and per-stage hazard taps.
// Optional build macro PIPE_SKID_EN adds a one-entry skid buffer ahead of stage 0.
// With the skid buffer, in_ready is driven directly from a flop.
module wb_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int RN_W   = 5,
    parameter int DEPTH  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_wreg,
    input  logic                    in_m2reg,
    input  logic [DATA_W-1:0]       in_mo,
    input  logic [DATA_W-1:0]       in_alu,
    input  logic [RN_W-1:0]         in_rn,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_wreg,
    output logic                    out_m2reg,
    output logic [DATA_W-1:0]       out_mo,
    output logic [DATA_W-1:0]       out_alu,
    output logic [RN_W-1:0]         out_rn,
    output logic [DATA_W-1:0]       out_wdata,
    output logic [DEPTH-1:0]        tap_wreg,
    output logic [DEPTH*RN_W-1:0]   tap_rn
);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  wreg_q;
    logic [DEPTH-1:0]  m2reg_q;
    logic [DATA_W-1:0] mo_q  [DEPTH];
    logic [DATA_W-1:0] alu_q [DEPTH];
    logic [RN_W-1:0]   rn_q  [DEPTH];

    logic [DEPTH-1:0]  stage_ready;

    logic              src_valid;
    logic              src_wreg;
    logic              src_m2reg;
    logic [DATA_W-1:0] src_mo;
    logic [DATA_W-1:0] src_alu;
    logic [RN_W-1:0]   src_rn;

    // A stage can load when it or any stage ahead of it has room, or the sink drains the last one
    always_comb begin
        logic chain;
        chain       = out_ready;
        stage_ready = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            chain          = chain | ~valid_q[i];
            stage_ready[i] = chain;
        end
    end

`ifdef PIPE_SKID_EN
    logic              skid_valid;
    logic              skid_wreg;
    logic              skid_m2reg;
    logic [DATA_W-1:0] skid_mo;
    logic [DATA_W-1:0] skid_alu;
    logic [RN_W-1:0]   skid_rn;

    assign in_ready = ~skid_valid;

    // A held skid entry is offered to stage 0 ahead of the input port
    always_comb begin
        src_valid = skid_valid | in_valid;
        src_wreg  = in_wreg;
        src_m2reg = in_m2reg;
        src_mo    = in_mo;
        src_alu   = in_alu;
        src_rn    = in_rn;
        if (skid_valid) begin
            src_wreg  = skid_wreg;
            src_m2reg = skid_m2reg;
            src_mo    = skid_mo;
            src_alu   = skid_alu;
            src_rn    = skid_rn;
        end
    end

    // Skid catches an accepted payload that stage 0 cannot take and empties once stage 0 pulls it
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_wreg  <= 1'b0;
            skid_m2reg <= 1'b0;
            skid_mo    <= '0;
            skid_alu   <= '0;
            skid_rn    <= '0;
        end else if (flush) begin
            skid_valid <= 1'b0;
            skid_wreg  <= 1'b0;
        end else if (skid_valid) begin
            if (stage_ready[0]) begin
                skid_valid <= 1'b0;
                skid_wreg  <= 1'b0;
            end
        end else if (in_valid && !stage_ready[0]) begin
            skid_valid <= 1'b1;
            skid_wreg  <= in_wreg;
            skid_m2reg <= in_m2reg;
            skid_mo    <= in_mo;
            skid_alu   <= in_alu;
            skid_rn    <= in_rn;
        end
    end
`else
    assign in_ready  = stage_ready[0];
    assign src_valid = in_valid;
    assign src_wreg  = in_wreg;
    assign src_m2reg = in_m2reg;
    assign src_mo    = in_mo;
    assign src_alu   = in_alu;
    assign src_rn    = in_rn;
`endif

    // Stages advance when ready, hold when blocked; flush only kills liveness and write enables
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            wreg_q  <= '0;
            m2reg_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mo_q[i]  <= '0;
                alu_q[i] <= '0;
                rn_q[i]  <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
            wreg_q  <= '0;
        end else begin
            if (stage_ready[0]) begin
                valid_q[0] <= src_valid;
                wreg_q[0]  <= src_valid & src_wreg;
                if (src_valid) begin
                    m2reg_q[0] <= src_m2reg;
                    mo_q[0]    <= src_mo;
                    alu_q[0]   <= src_alu;
                    rn_q[0]    <= src_rn;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (stage_ready[i]) begin
                    valid_q[i] <= valid_q[i-1];
                    wreg_q[i]  <= valid_q[i-1] & wreg_q[i-1];
                    if (valid_q[i-1]) begin
                        m2reg_q[i] <= m2reg_q[i-1];
                        mo_q[i]    <= mo_q[i-1];
                        alu_q[i]   <= alu_q[i-1];
                        rn_q[i]    <= rn_q[i-1];
                    end
                end
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_wreg  = wreg_q[DEPTH-1];
    assign out_m2reg = m2reg_q[DEPTH-1];
    assign out_mo    = mo_q[DEPTH-1];
    assign out_alu   = alu_q[DEPTH-1];
    assign out_rn    = rn_q[DEPTH-1];
    assign out_wdata = m2reg_q[DEPTH-1] ? mo_q[DEPTH-1] : alu_q[DEPTH-1];
    assign tap_wreg  = valid_q & wreg_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_tap
        assign tap_rn[g*RN_W +: RN_W] = rn_q[g];
    end

endmodule

// File: tb/tb_wb_pipe_reg.sv
// tb_wb_pipe_reg: drives DEPTH=1, 3 and 4 instances of wb_pipe_reg from shared stimulus.
// Each instance is compared against a slot-occupancy reference model.
// Honours PIPE_SKID_EN when the build defines it.
module tb_wb_pipe_reg;

    typedef struct packed {
        logic        v;
        logic        w;
        logic        m;
        logic [31:0] mo;
        logic [31:0] alu;
        logic [4:0]  rn;
    } ent_t;

`ifdef PIPE_SKID_EN
    localparam int STALL_ACCEPT = 4;
`else
    localparam int STALL_ACCEPT = 3;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        in_wreg;
    logic        in_m2reg;
    logic [31:0] in_mo;
    logic [31:0] in_alu;
    logic [4:0]  in_rn;
    logic        flush;
    logic        out_ready;

    logic [2:0]       irdy;
    logic [2:0]       ov;
    logic [2:0]       ow;
    logic [2:0]       om;
    logic [2:0][31:0] omo;
    logic [2:0][31:0] oalu;
    logic [2:0][31:0] owd;
    logic [2:0][4:0]  orn;
    logic [0:0]       tw1;
    logic [2:0]       tw3;
    logic [3:0]       tw4;
    logic [4:0]       tr1;
    logic [14:0]      tr3;
    logic [19:0]      tr4;

    ent_t ms  [3][8];
    ent_t msk [3];
    int   dep [3] = '{1, 3, 4};
    int   acc [3] = '{0, 0, 0};
    int   dlv [3] = '{0, 0, 0};
    int   total = 0;
    int   bad   = 0;
    bit   check_en = 1'b0;

    wb_pipe_reg #(.DATA_W(32), .RN_W(5), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[0]),
        .in_wreg(in_wreg), .in_m2reg(in_m2reg), .in_mo(in_mo), .in_alu(in_alu),
        .in_rn(in_rn), .flush(flush), .out_valid(ov[0]), .out_ready(out_ready),
        .out_wreg(ow[0]), .out_m2reg(om[0]), .out_mo(omo[0]), .out_alu(oalu[0]),
        .out_rn(orn[0]), .out_wdata(owd[0]), .tap_wreg(tw1), .tap_rn(tr1)
    );

    wb_pipe_reg #(.DATA_W(32), .RN_W(5), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[1]),
        .in_wreg(in_wreg), .in_m2reg(in_m2reg), .in_mo(in_mo), .in_alu(in_alu),
        .in_rn(in_rn), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready),
        .out_wreg(ow[1]), .out_m2reg(om[1]), .out_mo(omo[1]), .out_alu(oalu[1]),
        .out_rn(orn[1]), .out_wdata(owd[1]), .tap_wreg(tw3), .tap_rn(tr3)
    );

    wb_pipe_reg #(.DATA_W(32), .RN_W(5), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[2]),
        .in_wreg(in_wreg), .in_m2reg(in_m2reg), .in_mo(in_mo), .in_alu(in_alu),
        .in_rn(in_rn), .flush(flush), .out_valid(ov[2]), .out_ready(out_ready),
        .out_wreg(ow[2]), .out_m2reg(om[2]), .out_mo(omo[2]), .out_alu(oalu[2]),
        .out_rn(orn[2]), .out_wdata(owd[2]), .tap_wreg(tw4), .tap_rn(tr4)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] obsTapWreg(input int k);
        case (k)
            0:       return {7'b0, tw1};
            1:       return {5'b0, tw3};
            default: return {4'b0, tw4};
        endcase
    endfunction

    function automatic logic [39:0] obsTapRn(input int k);
        case (k)
            0:       return {35'b0, tr1};
            1:       return {25'b0, tr3};
            default: return {20'b0, tr4};
        endcase
    endfunction

    // Compare every instance against its model slots; also tally observed handshakes
    task automatic checkAll();
        for (int k = 0; k < 3; k++) begin
            int          d;
            ent_t        last;
            logic [7:0]  etw;
            logic [39:0] otr;
            logic [31:0] ewd;
            string       p;
            bit          erdy;
            d    = dep[k];
            last = ms[k][d-1];
            etw  = '0;
            otr  = obsTapRn(k);
            p    = $sformatf("d%0d", d);
            checkOutput({p, "_out_valid"}, 64'(ov[k]), 64'(last.v));
            if (last.v) begin
                ewd = last.m ? last.mo : last.alu;
                checkOutput({p, "_out_wdata"}, 64'(owd[k]), 64'(ewd));
                checkOutput({p, "_out_rn"}, 64'(orn[k]), 64'(last.rn));
                checkOutput({p, "_out_wreg"}, 64'(ow[k]), 64'(last.w));
                checkOutput({p, "_out_m2reg"}, 64'(om[k]), 64'(last.m));
                checkOutput({p, "_out_mo"}, 64'(omo[k]), 64'(last.mo));
                checkOutput({p, "_out_alu"}, 64'(oalu[k]), 64'(last.alu));
            end
            for (int i = 0; i < d; i++) begin
                etw[i] = ms[k][i].v & ms[k][i].w;
                if (ms[k][i].v)
                    checkOutput($sformatf("%s_tap_rn_s%0d", p, i), 64'(otr[i*5 +: 5]), 64'(ms[k][i].rn));
            end
            checkOutput({p, "_tap_wreg"}, 64'(obsTapWreg(k)), 64'(etw));
`ifdef PIPE_SKID_EN
            erdy = !msk[k].v;
`else
            erdy = out_ready;
            for (int i = 0; i < d; i++)
                if (!ms[k][i].v) erdy = 1'b1;
`endif
            checkOutput({p, "_in_ready"}, 64'(irdy[k]), 64'(erdy));
            if (in_valid && irdy[k]) acc[k]++;
            if (ov[k] && out_ready) dlv[k]++;
        end
    endtask

    // Reference: sink takes the oldest entry, entries slide into any free slot ahead, input fills slot 0
    task automatic modelStep(input int k);
        int   d;
        ent_t inp;
        d       = dep[k];
        inp     = '0;
        inp.v   = 1'b1;
        inp.w   = in_wreg;
        inp.m   = in_m2reg;
        inp.mo  = in_mo;
        inp.alu = in_alu;
        inp.rn  = in_rn;
        if (rst) begin
            for (int i = 0; i < 8; i++) ms[k][i] = '0;
            msk[k] = '0;
            return;
        end
        if (flush) begin
            for (int i = 0; i < 8; i++) begin
                ms[k][i].v = 1'b0;
                ms[k][i].w = 1'b0;
            end
            msk[k].v = 1'b0;
            msk[k].w = 1'b0;
            return;
        end
        if (ms[k][d-1].v && out_ready) begin
            ms[k][d-1].v = 1'b0;
            ms[k][d-1].w = 1'b0;
        end
        for (int i = d - 2; i >= 0; i--) begin
            if (ms[k][i].v && !ms[k][i+1].v) begin
                ms[k][i+1] = ms[k][i];
                ms[k][i].v = 1'b0;
                ms[k][i].w = 1'b0;
            end
        end
`ifdef PIPE_SKID_EN
        if (msk[k].v) begin
            if (!ms[k][0].v) begin
                ms[k][0] = msk[k];
                msk[k].v = 1'b0;
                msk[k].w = 1'b0;
            end
        end else if (in_valid) begin
            if (!ms[k][0].v) ms[k][0] = inp;
            else             msk[k]   = inp;
        end
`else
        if (in_valid && !ms[k][0].v) ms[k][0] = inp;
`endif
    endtask

    // One clock of stimulus: check at the falling edge, advance the model at the rising edge
    task automatic applyStimulus(input bit r, input bit iv, input bit w, input bit m,
                                 input logic [31:0] mo, input logic [31:0] alu,
                                 input logic [4:0] rn, input bit fl, input bit ordy);
        rst       = r;
        in_valid  = iv;
        in_wreg   = w;
        in_m2reg  = m;
        in_mo     = mo;
        in_alu    = alu;
        in_rn     = rn;
        flush     = fl;
        out_ready = ordy;
        @(negedge clk);
        if (check_en) checkAll();
        @(posedge clk);
        for (int k = 0; k < 3; k++) modelStep(k);
        if (r) check_en = 1'b1;
        #1;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0, 1'b0, ordy);
    endtask

    task automatic fillThree();
        for (int c = 0; c < 3; c++)
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, $urandom, $urandom, 5'(c + 1), 1'b0, 1'b0);
    endtask

    initial begin
        int a0;
        int d0;
        rst = 1'b1; in_valid = 1'b1; in_wreg = 1'b1; in_m2reg = 1'b1;
        in_mo = 32'h0; in_alu = 32'h0; in_rn = 5'h0; flush = 1'b0; out_ready = 1'b1;

        // reset held two cycles with input offered
        for (int i = 0; i < 2; i++)
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, $urandom, $urandom, 5'($urandom), 1'b0, 1'b1);
        checkOutput("rst_out_valid", 64'(ov[0]), 64'h0);
        checkOutput("rst_out_wdata", 64'(owd[0]), 64'h0);
        checkOutput("rst_tap_wreg", 64'(tw1), 64'h0);

        // first payload through the single-stage pipe
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678, 5'd5, 1'b0, 1'b1);
        checkOutput("d1_first_wdata", 64'(owd[0]), 64'hDEADBEEF);
        checkOutput("d1_first_rn", 64'(orn[0]), 64'd5);
        checkOutput("d1_first_tap", 64'(tw1), 64'h1);
        idle(5, 1'b1);

        // streaming through three stages at full rate
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b0, c < 4, 1'b1, 1'b0, $urandom, 32'(c + 1), 5'($urandom), 1'b0, 1'b1);
            if (c >= 2) begin
                checkOutput("d3_stream_valid", 64'(ov[1]), 64'h1);
                checkOutput("d3_stream_wdata", 64'(owd[1]), 64'(c - 1));
            end
        end
        idle(6, 1'b1);

        // stall: five offers against a blocked sink, then drain
        a0 = acc[1];
        for (int c = 0; c < 5; c++)
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, $urandom, $urandom, 5'(10 + c), 1'b0, 1'b0);
        checkOutput("d3_stall_accepted", 64'(acc[1] - a0), 64'(STALL_ACCEPT));
        d0 = dlv[1];
        idle(8, 1'b1);
        checkOutput("d3_stall_drained", 64'(dlv[1] - d0), 64'(STALL_ACCEPT));

        // flush a full pipe while rn=9 is offered
        fillThree();
        checkOutput("d3_full_taps", 64'(tw3), 64'h7);
        d0 = dlv[1];
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, $urandom, $urandom, 5'd9, 1'b1, 1'b0);
        checkOutput("d3_flush_valid", 64'(ov[1]), 64'h0);
        checkOutput("d3_flush_taps", 64'(tw3), 64'h0);
        idle(6, 1'b1);
        checkOutput("d3_flush_no_output", 64'(dlv[1] - d0), 64'h0);

        // flush while the sink takes the output payload
        fillThree();
        d0 = dlv[1];
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, $urandom, $urandom, 5'd9, 1'b1, 1'b1);
        checkOutput("d3_flush_sink_commit", 64'(dlv[1] - d0), 64'h1);
        idle(4, 1'b1);
        checkOutput("d3_flush_nothing_follows", 64'(dlv[1] - d0), 64'h1);
        idle(4, 1'b1);

        // bubble collapse on four stages with a blocked sink
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, $urandom, $urandom, 5'd1, 1'b0, 1'b0);
        idle(1, 1'b0);
        for (int c = 2; c <= 4; c++)
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, $urandom, $urandom, 5'(c), 1'b0, 1'b0);
        idle(2, 1'b0);
        checkOutput("d4_bubble_taps", 64'(tw4), 64'hF);
        checkOutput("d4_bubble_tap_rn", 64'(tr4), 64'({5'd1, 5'd2, 5'd3, 5'd4}));
        idle(8, 1'b1);

        // randomized traffic with occasional flush and reset
        for (int c = 0; c < 400; c++)
            applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                          1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
                          $urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0);
        idle(10, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
